// File: rtl/evo_array_pkg.sv
// ---------------------------------------------------------------------------
// evo_array_pkg
// Shared types and helpers for the evolvable LUT array:
//   state_t       configuration loader FSM states
//   cell_cfg_t    decoded cell configuration word {func, sel_a, sel_b}
//   clog2_min1    ceil(log2(n)) with a floor of 1 bit
//   cfg_width     config word width for a given select width
//   unpack_cell   split a raw config word into cell_cfg_t for a select width
// ---------------------------------------------------------------------------
package evo_array_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    // Selects are carried at a fixed generous width so the struct is
    // independent of the array size; unused upper bits are always zero.
    localparam int SEL_W_MAX  = 16;
    localparam int WORD_W_MAX = 4 + 2 * SEL_W_MAX;

    typedef struct packed {
        logic [3:0]           func;
        logic [SEL_W_MAX-1:0] sel_a;
        logic [SEL_W_MAX-1:0] sel_b;
    } cell_cfg_t;

    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int cfg_width(input int sw);
        return 4 + 2 * sw;
    endfunction

    // Raw word layout is {func[3:0], sel_a[sw-1:0], sel_b[sw-1:0]}.
    function automatic cell_cfg_t unpack_cell(input logic [WORD_W_MAX-1:0] word,
                                              input int sw);
        cell_cfg_t             c;
        logic [WORD_W_MAX-1:0] m;
        m       = (WORD_W_MAX'(1) << sw) - WORD_W_MAX'(1);
        c.sel_b = SEL_W_MAX'(word & m);
        c.sel_a = SEL_W_MAX'((word >> sw) & m);
        c.func  = 4'(word >> (2 * sw));
        return c;
    endfunction

endpackage

// File: rtl/evo_array_cell.sv
// ---------------------------------------------------------------------------
// evo_cell
// One 2-input LUT cell. Output = func[{srcA, srcB}], srcA is the MSB.
// Only sources below LIMIT are reachable; any other select reads 0, which
// also keeps the array free of combinational loops.
// Ports:
//   i_src  [LIMIT-1:0]  sources visible to this cell
//   i_cfg  cell_cfg_t   decoded configuration
//   o_y                 cell output (combinational)
// ---------------------------------------------------------------------------
module evo_cell
    import evo_array_pkg::*;
#(
    parameter int LIMIT = 3
) (
    input  logic [LIMIT-1:0] i_src,
    input  cell_cfg_t        i_cfg,
    output logic             o_y
);

    logic w_a;
    logic w_b;

    // Source selection and LUT lookup
    always_comb begin
        w_a = 1'b0;
        w_b = 1'b0;
        for (int i = 0; i < LIMIT; i++) begin
            w_a = w_a | ((i_cfg.sel_a == SEL_W_MAX'(i)) & i_src[i]);
            w_b = w_b | ((i_cfg.sel_b == SEL_W_MAX'(i)) & i_src[i]);
        end
        o_y = i_cfg.func[{w_a, w_b}];
    end

endmodule

// File: rtl/evo_array.sv
// ---------------------------------------------------------------------------
// evo_array
// ROWS x COLS grid of 2-input LUT cells, feed-forward by column, with a
// shadow/active configuration scheme loaded through a valid/ready stream.
// Optional feature macro: EVO_ARRAY_READBACK_EN adds rb_addr/rb_data.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   in    [N_IN-1:0]      primary inputs
//   out   [N_OUT-1:0]     registered outputs (1-cycle latency)
//   cfg_start             begin (or restart) a load
//   cfg_valid, cfg_data   config word stream, accepted when cfg_ready
//   cfg_ready             high only while loading
//   cfg_done              one-cycle pulse when the new config is committed
//   cfg_err               sticky: an accepted word had an illegal select
//   rb_addr, rb_data      (readback build) registered active-word readback
// Load order: C cell words (k = c*ROWS + r), then N_OUT output-select words.
// ---------------------------------------------------------------------------
module evo_array
    import evo_array_pkg::*;
#(
    parameter int N_IN  = 3,
    parameter int N_OUT = 2,
    parameter int ROWS  = 3,
    parameter int COLS  = 3
) (
    input  logic                                                    clk,
    input  logic                                                    rst_n,
    input  logic [N_IN-1:0]                                         in,
    output logic [N_OUT-1:0]                                        out,
    input  logic                                                    cfg_start,
    input  logic                                                    cfg_valid,
    input  logic [cfg_width(clog2_min1(N_IN + ROWS * COLS))-1:0]    cfg_data,
    output logic                                                    cfg_ready,
    output logic                                                    cfg_done,
    output logic                                                    cfg_err
`ifdef EVO_ARRAY_READBACK_EN
    ,
    input  logic [clog2_min1(ROWS * COLS + N_OUT)-1:0]              rb_addr,
    output logic [cfg_width(clog2_min1(N_IN + ROWS * COLS))-1:0]    rb_data
`endif
);

    localparam int C  = ROWS * COLS;
    localparam int S  = N_IN + C;
    localparam int SW = clog2_min1(S);
    localparam int CW = cfg_width(SW);
    localparam int NW = C + N_OUT;
    localparam int AW = clog2_min1(NW);

    state_t           r_state;
    state_t           w_next_state;
    logic [AW-1:0]    r_cnt;
    logic [CW-1:0]    r_shd [NW];
    logic [CW-1:0]    r_act [NW];
    logic [CW-1:0]    w_cfg [NW];
    logic [N_OUT-1:0] r_out;
    logic [N_OUT-1:0] w_out_nxt;
    logic             r_err;
    logic             w_accept;
    logic             w_last;
    logic             w_restart;
    logic             w_word_bad;
    cell_cfg_t        w_word_cfg;
    logic [S-1:0]     w_all;

    // A start in LOAD wins over a concurrent word; start in COMMIT is ignored.
    assign w_restart = cfg_start & (r_state != ST_COMMIT);
    assign w_accept  = cfg_valid & (r_state == ST_LOAD) & ~cfg_start;
    assign w_last    = (r_cnt == AW'(NW - 1));

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (cfg_start) w_next_state = ST_LOAD;
                else           w_next_state = ST_IDLE;
            end
            ST_LOAD: begin
                if (cfg_start)               w_next_state = ST_LOAD;
                else if (w_accept && w_last) w_next_state = ST_COMMIT;
                else                         w_next_state = ST_LOAD;
            end
            ST_COMMIT: w_next_state = ST_IDLE;
            default:   w_next_state = ST_IDLE;
        endcase
    end

    // Legality of the word currently offered, judged by its load position
    always_comb begin
        w_word_bad = 1'b0;
        w_word_cfg = unpack_cell(WORD_W_MAX'(cfg_data), SW);
        for (int k = 0; k < C; k++) begin
            w_word_bad = w_word_bad | ((r_cnt == AW'(k)) &
                ((w_word_cfg.sel_a >= SEL_W_MAX'(N_IN + (k / ROWS) * ROWS)) |
                 (w_word_cfg.sel_b >= SEL_W_MAX'(N_IN + (k / ROWS) * ROWS))));
        end
        for (int j = 0; j < N_OUT; j++) begin
            w_word_bad = w_word_bad | ((r_cnt == AW'(C + j)) &
                ({1'b0, cfg_data[SW-1:0]} >= (SW + 1)'(S)));
        end
    end

    // Word counter, shadow config and sticky error flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= {AW{1'b0}};
            r_err <= 1'b0;
            for (int k = 0; k < NW; k++) r_shd[k] <= {CW{1'b0}};
        end else if (w_restart) begin
            r_cnt <= {AW{1'b0}};
            r_err <= 1'b0;
            for (int k = 0; k < NW; k++) r_shd[k] <= {CW{1'b0}};
        end else if (w_accept) begin
            r_shd[r_cnt] <= cfg_data;
            r_cnt        <= w_last ? {AW{1'b0}} : r_cnt + AW'(1);
            r_err        <= r_err | w_word_bad;
        end
    end

    // Active config takes the shadow at the end of COMMIT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NW; k++) r_act[k] <= {CW{1'b0}};
        end else if (r_state == ST_COMMIT) begin
            for (int k = 0; k < NW; k++) r_act[k] <= r_shd[k];
        end
    end

    // During COMMIT the array already evaluates the shadow, so the output
    // register captures the new behaviour on the same edge that commits it.
    always_comb begin
        for (int k = 0; k < NW; k++) begin
            w_cfg[k] = (r_state == ST_COMMIT) ? r_shd[k] : r_act[k];
        end
    end

    // Column-by-column source vectors: column c sees inputs plus columns < c.
    genvar gc, gr;
    for (gc = 0; gc < COLS; gc++) begin : g_col
        localparam int LIMIT = N_IN + gc * ROWS;
        logic [S-1:0]    w_src;
        logic [ROWS-1:0] w_y;
        if (gc == 0) begin : g_first
            assign w_src = S'(in);
        end else begin : g_next
            assign w_src = g_col[gc-1].w_src |
                           (S'(g_col[gc-1].w_y) << (N_IN + (gc - 1) * ROWS));
        end
        for (gr = 0; gr < ROWS; gr++) begin : g_row
            cell_cfg_t w_ccfg;
            assign w_ccfg = unpack_cell(WORD_W_MAX'(w_cfg[gc * ROWS + gr]), SW);
            evo_cell #(.LIMIT(LIMIT)) u_cell (
                .i_src (w_src[LIMIT-1:0]),
                .i_cfg (w_ccfg),
                .o_y   (w_y[gr])
            );
        end
    end

    assign w_all = g_col[COLS-1].w_src |
                   (S'(g_col[COLS-1].w_y) << (N_IN + (COLS - 1) * ROWS));

    // Output selects: low SW bits of each output word, >= S reads 0
    always_comb begin
        w_out_nxt = {N_OUT{1'b0}};
        for (int j = 0; j < N_OUT; j++) begin
            for (int i = 0; i < S; i++) begin
                w_out_nxt[j] = w_out_nxt[j] |
                               ((w_cfg[C + j][SW-1:0] == SW'(i)) & w_all[i]);
            end
        end
    end

    // Output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out <= {N_OUT{1'b0}};
        end else begin
            r_out <= w_out_nxt;
        end
    end

    assign out       = r_out;
    assign cfg_ready = (r_state == ST_LOAD);
    assign cfg_done  = (r_state == ST_COMMIT);
    assign cfg_err   = r_err;

`ifdef EVO_ARRAY_READBACK_EN
    logic [CW-1:0] r_rb;

    // Registered readback of the active config; out-of-range reads 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rb <= {CW{1'b0}};
        end else begin
            r_rb <= {CW{1'b0}};
            for (int k = 0; k < NW; k++) begin
                if (rb_addr == AW'(k)) r_rb <= r_act[k];
            end
        end
    end

    assign rb_data = r_rb;
`endif

endmodule

// File: doc/evo_array.md
EVO_ARRAY -- requirements
Module: evo_array

Interface
REQ-001 SHALL have parameter N_IN, default 3, number of primary inputs.
REQ-002 SHALL have parameter N_OUT, default 2, number of primary outputs.
REQ-003 SHALL have parameters ROWS, default 3, and COLS, default 3, giving the cell grid size. C = ROWS*COLS; source count S = N_IN + C; SW = clog2(S); CW = 4 + 2*SW.
REQ-004 SHALL have ports: clk  in  1  sole clock; rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports: in  in  N_IN  primary inputs; out  out  N_OUT  registered outputs.
REQ-006 SHALL have ports: cfg_start  in  1  begin load; cfg_valid  in  1  word valid; cfg_data  in  CW  config word; cfg_ready  out  1  accepting words.
REQ-007 SHALL have ports: cfg_done  out  1  one-cycle commit pulse; cfg_err  out  1  sticky illegal-reference flag.

Function
REQ-008 Cell k = c*ROWS + r SHALL be a 2-input LUT: word {func[3:0], selA, selB}; output = func[{srcA,srcB}], srcA is the MSB.
REQ-009 Source index i < N_IN SHALL be in[i]; index N_IN+k SHALL be the output of cell k.
REQ-010 A cell in column c SHALL only use sources < N_IN + c*ROWS; any other select, including >= S, SHALL read constant 0.
REQ-011 Output j SHALL select source out_sel[j], taken from bits [SW-1:0] of its config word; bits above are ignored. Select >= S SHALL read 0.
REQ-012 out SHALL register the array result every cycle; latency from in to out is 1 cycle.
REQ-013 Load order SHALL be C cell words (k = 0..C-1), then N_OUT output words, for C+N_OUT words in total.
REQ-014 FSM states SHALL be IDLE, LOAD and COMMIT: IDLE->LOAD on cfg_start; LOAD->COMMIT when the final word is accepted; COMMIT->IDLE after 1 cycle.
REQ-015 cfg_ready SHALL be 1 only in LOAD. A word SHALL be accepted when cfg_valid and cfg_ready are both 1, and written to the shadow config.
REQ-016 In COMMIT, shadow SHALL be copied to active and cfg_done SHALL pulse 1. out SHALL reflect the new config from the cycle after COMMIT.
REQ-017 cfg_start in LOAD SHALL restart the word count at 0. Active config SHALL be unchanged and the shadow contents discarded.
REQ-018 cfg_start in COMMIT SHALL be ignored.
REQ-019 cfg_err SHALL set on acceptance of a word violating REQ-010 or REQ-011, and clear on cfg_start. The word is still loaded.
REQ-020 Evaluation SHALL continue with the active config throughout LOAD.

Reset
REQ-021 Reset SHALL set: FSM to IDLE, word count 0, shadow and active config all zero, out 0, cfg_ready 0, cfg_done 0, cfg_err 0.
REQ-022 Reset asserted mid-LOAD SHALL abandon the load; no partial commit.
REQ-023 After reset the all-zero config SHALL hold: every cell outputs 0 and every out[j] follows in[0].

Configuration
REQ-024 With EVO_ARRAY_READBACK_EN defined, the block SHALL add ports rb_addr  in  clog2(C+N_OUT)  word index and rb_data  out  CW  active config word (registered, 1-cycle latency, 0 for an out-of-range address, 0 in reset).
REQ-025 Without EVO_ARRAY_READBACK_EN, those ports and their logic SHALL be absent. All other behaviour is identical.

Structure
REQ-026 A shared package SHALL hold the FSM state enum, the cell config word struct (func, selA, selB) and the clog2-based width functions.
REQ-027 The 2-input LUT cell SHALL be a sub-module, evo_cell, instantiated C times.

Verification (defaults: S=12, SW=4, CW=12, 11 words)
REQ-028 Reset: rst_n=0 -> out=0, cfg_ready=0, cfg_err=0. Release, in=3'b101 -> out=2'b11 one cycle later.
REQ-029 Load cell0 = {4'b0110, 4'd0, 4'd1} (XOR of in0 and in1), other cells 0, out_sel = {3, 2} (out[0]=cell0, out[1]=in[2]). Then in=3'b011 -> cfg_done pulse, next-cycle out=2'b00; in=3'b101 -> out=2'b11.
REQ-030 Backpressure: cfg_valid toggles every other cycle -> exactly 11 words accepted, COMMIT 1 cycle after the 11th.
REQ-031 Illegal reference: cell0 selA=4'd5 (cell2, same column) -> cfg_err=1, cell0 reads 0. A subsequent cfg_start clears cfg_err.
REQ-032 Restart: cfg_start after 6 words, then 11 fresh words -> out unchanged during load; new config only after the single cfg_done.
REQ-033 With EVO_ARRAY_READBACK_EN: rb_addr=0 after the REQ-029 load -> rb_data=12'h601 one cycle later; rb_addr=11 -> 0.
